// File: rtl/mbist_pkg.sv
// March C- element table, FSM/op encodings and compare-pipeline tag for the MBIST controller.
// Pure declarations: no latency, no backpressure.
// Table entries run op[0] then op[1]; OP_NONE in op[1] marks a single-op element.
package mbist_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, OP, DRAIN, DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_R0, OP_R1, OP_W0, OP_W1} op_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_ANY} dir_t;

  typedef struct packed {
    dir_t          dir;
    op_t [1:0]     op;
  } march_elem_t;

  typedef struct packed {
    logic          en;
    logic [2:0]    idx;
  } cmp_tag_t;

  localparam int MAX_ELEM = 6;

  function automatic march_elem_t mk_elem(dir_t d, op_t first, op_t second);
    march_elem_t e;
    e.dir   = d;
    e.op[0] = first;
    e.op[1] = second;
    return e;
  endfunction

  localparam march_elem_t MARCH_C_MINUS [MAX_ELEM] = '{
    mk_elem(DIR_ANY,  OP_W0, OP_NONE),
    mk_elem(DIR_UP,   OP_R0, OP_W1),
    mk_elem(DIR_UP,   OP_R1, OP_W0),
    mk_elem(DIR_DOWN, OP_R0, OP_W1),
    mk_elem(DIR_DOWN, OP_R1, OP_W0),
    mk_elem(DIR_ANY,  OP_R0, OP_NONE)
  };

  function automatic logic op_is_read(op_t o);
    return (o == OP_R0) || (o == OP_R1);
  endfunction

  function automatic logic op_is_write(op_t o);
    return (o == OP_W0) || (o == OP_W1);
  endfunction

  function automatic logic op_bit(op_t o);
    return (o == OP_R1) || (o == OP_W1);
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Delays {cmp_en, elem_idx} to line up with the comparator result of a read.
// Latency RD_LAT cycles; no backpressure, flush clears every stage.
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       cmp_en,
  input  logic [2:0] elem_idx,
  output logic       dly_cmp_en,
  output logic [2:0] dly_elem_idx
);

  cmp_tag_t stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        stage[i] <= stage[i-1];
      end
      stage[0] <= '{en: cmp_en, idx: elem_idx};
    end
  end

  assign dly_cmp_en   = stage[RD_LAT-1].en;
  assign dly_elem_idx = stage[RD_LAT-1].idx;

endmodule

// File: rtl/mbist_march_controller.sv
// March C- MBIST sequencer: drives counter/memory strobes and collects a sticky fail through an RD_LAT pipe.
// One memory op per cycle in OP; no backpressure, start is only honoured in IDLE/DONE.
// Optional MBIST_FAIL_STOP_EN: first recorded mismatch ends the run in DONE on the following edge.
module mbist_march_controller
  import mbist_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_ELEM = 6,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cout,
  input  logic              cmp_fail,
  output logic              ld,
  output logic              NbarT,
  output logic              cnt_en,
  output logic              addr_up,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] pat,
  output logic              cmp_en,
  output logic [2:0]        elem_idx,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem
);

  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);
  localparam logic [1:0] LAST_DRAIN = 2'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  elem_q, elem_nxt;
  logic        op_idx_q, op_idx_nxt;
  logic [1:0]  drain_q, drain_nxt;
  logic        fail_q;
  logic [2:0]  fail_elem_q;
  logic        clr_res;
  logic        run_st;
  logic        stop;
  logic        hit;
  logic        dly_cmp_en;
  logic [2:0]  dly_elem_idx;
  march_elem_t cur;
  op_t         cur_op;
  logic        last_slot;

  assign cur       = MARCH_C_MINUS[elem_q];
  assign cur_op    = cur.op[op_idx_q];
  assign last_slot = op_idx_q || (cur.op[1] == OP_NONE);
  assign run_st    = (state == LOAD) || (state == OP) || (state == DRAIN);
  assign hit       = run_st && dly_cmp_en && cmp_fail;

`ifdef MBIST_FAIL_STOP_EN
  assign stop = run_st && fail_q;
`else
  assign stop = 1'b0;
`endif

  mbist_cmp_pipe #(.RD_LAT(RD_LAT)) u_cmp_pipe (
    .clk          (clk),
    .rst          (rst),
    .flush        (stop),
    .cmp_en       (cmp_en),
    .elem_idx     (elem_q),
    .dly_cmp_en   (dly_cmp_en),
    .dly_elem_idx (dly_elem_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      elem_q   <= '0;
      op_idx_q <= 1'b0;
      drain_q  <= '0;
    end else begin
      state    <= state_nxt;
      elem_q   <= elem_nxt;
      op_idx_q <= op_idx_nxt;
      drain_q  <= drain_nxt;
    end
  end

  // fail_elem only latches the first mismatch of a run
  always_ff @(posedge clk) begin
    if (rst || clr_res) begin
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
    end else if (hit) begin
      fail_q <= 1'b1;
      if (!fail_q) begin
        fail_elem_q <= dly_elem_idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    elem_nxt   = elem_q;
    op_idx_nxt = op_idx_q;
    drain_nxt  = drain_q;
    clr_res    = 1'b0;
    ld         = 1'b0;
    NbarT      = 1'b0;
    cnt_en     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    cmp_en     = 1'b0;
    pat        = '0;
    busy       = 1'b0;
    done       = 1'b0;
    addr_up    = (cur.dir != DIR_DOWN);

    unique case (state)
      IDLE: begin
        ld = 1'b1;
        if (start) begin
          state_nxt = LOAD;
          elem_nxt  = '0;
          clr_res   = 1'b1;
        end
      end
      LOAD: begin
        ld         = 1'b1;
        NbarT      = 1'b1;
        busy       = 1'b1;
        op_idx_nxt = 1'b0;
        state_nxt  = OP;
      end
      OP: begin
        NbarT  = 1'b1;
        busy   = 1'b1;
        mem_re = op_is_read(cur_op);
        cmp_en = op_is_read(cur_op);
        mem_we = op_is_write(cur_op);
        pat    = {DATA_W{op_bit(cur_op)}};
        if (last_slot) begin
          cnt_en     = 1'b1;
          op_idx_nxt = 1'b0;
          // cout only ends an element when the counter is actually stepping
          if (cout) begin
            if (elem_q == LAST_ELEM) begin
              state_nxt = DRAIN;
              drain_nxt = '0;
            end else begin
              elem_nxt  = elem_q + 3'd1;
              state_nxt = LOAD;
            end
          end
        end else begin
          op_idx_nxt = 1'b1;
        end
      end
      DRAIN: begin
        NbarT = 1'b1;
        busy  = 1'b1;
        if (drain_q == LAST_DRAIN) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_q + 2'd1;
        end
      end
      DONE: begin
        ld   = 1'b1;
        done = 1'b1;
        if (start) begin
          state_nxt = LOAD;
          elem_nxt  = '0;
          clr_res   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (stop) begin
      state_nxt = DONE;
    end
  end

  assign elem_idx  = elem_q;
  assign fail      = fail_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_controller.sv
// Bench: two controllers (RD_LAT 1 and 3) each driving a behavioural counter, memory and delayed comparator.
// Run results and the RD_LAT=1 op stream are queued at launch and checked as the DUT produces them.
module tb_mbist_march_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [1:0] max_addr;

  logic       cout      [2];
  logic       cmp_fail  [2];
  logic       ld        [2];
  logic       NbarT     [2];
  logic       cnt_en    [2];
  logic       addr_up   [2];
  logic       mem_we    [2];
  logic       mem_re    [2];
  logic [7:0] pat       [2];
  logic       cmp_en    [2];
  logic [2:0] elem_idx  [2];
  logic       busy      [2];
  logic       done      [2];
  logic       fail      [2];
  logic [2:0] fail_elem [2];

  logic       fault_on   [2];
  logic [2:0] fault_elem [2];
  int         fault_read [2];

  int n_we [2];
  int n_re [2];
  int n_dn [2];
  int bad_dn [2];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         edges;
    logic       fail;
    logic [2:0] fe;
    int         nwe;
    int         nre;
  } exp_t;

  typedef struct {
    logic we;
    logic re;
    logic d;
    logic up;
  } op_exp_t;

  exp_t    sb0 [$];
  exp_t    sb1 [$];
  op_exp_t opq [$];
  logic    chk_ops = 1'b0;

  // op codes: 1 r0, 2 r1, 3 w0, 4 w1, 0 none
  int   tb_ops [6][2] = '{'{3, 0}, '{1, 4}, '{2, 3}, '{1, 4}, '{2, 3}, '{1, 0}};
  logic tb_up  [6]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [1:0] addr = '0;
    logic [7:0] mem [4];
    logic [3:0] sh = '0;
    int         rd_cnt = 0;
    logic       mis;

    mbist_march_controller #(.DATA_W(8), .NUM_ELEM(6), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cout      (cout[g]),
      .cmp_fail  (cmp_fail[g]),
      .ld        (ld[g]),
      .NbarT     (NbarT[g]),
      .cnt_en    (cnt_en[g]),
      .addr_up   (addr_up[g]),
      .mem_we    (mem_we[g]),
      .mem_re    (mem_re[g]),
      .pat       (pat[g]),
      .cmp_en    (cmp_en[g]),
      .elem_idx  (elem_idx[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .fail      (fail[g]),
      .fail_elem (fail_elem[g])
    );

    assign cout[g]     = addr_up[g] ? (addr == max_addr) : (addr == 2'd0);
    assign mis         = mem_re[g] && ((mem[addr] !== pat[g]) ||
                         (fault_on[g] && elem_idx[g] == fault_elem[g] && rd_cnt == fault_read[g]));
    assign cmp_fail[g] = sh[LAT-1];

    always @(posedge clk) begin
      if (ld[g])          addr <= addr_up[g] ? 2'd0 : max_addr;
      else if (cnt_en[g]) addr <= addr_up[g] ? addr + 2'd1 : addr - 2'd1;
      if (mem_we[g]) mem[addr] <= pat[g];
      if (ld[g])          rd_cnt <= 0;
      else if (mem_re[g]) rd_cnt <= rd_cnt + 1;
      sh <= {sh[2:0], mis};
    end

    always @(negedge clk) begin
      if (!busy[g] && start) begin
        n_we[g] = 0; n_re[g] = 0; n_dn[g] = 0; bad_dn[g] = 0;
      end else if (busy[g]) begin
        if (mem_we[g]) n_we[g]++;
        if (mem_re[g]) n_re[g]++;
        if (!addr_up[g] && (mem_we[g] || mem_re[g])) n_dn[g]++;
        if (!addr_up[g] && elem_idx[g] != 3'd3 && elem_idx[g] != 3'd4) bad_dn[g]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_ops && (mem_we[0] || mem_re[0])) begin
      op_exp_t e;
      n_assert++;
      assert (opq.size() > 0) else begin
        n_fail++;
        $error("FAIL op_extra observed=%0d expected=0 extra ops", 1);
      end
      if (opq.size() > 0) begin
        e = opq.pop_front();
        chk("op_we_re_pat_up", {21'd0, mem_we[0], mem_re[0], pat[0], addr_up[0]},
            {21'd0, e.we, e.re, {8{e.d}}, e.up});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ops(input int n);
    for (int e = 0; e < 6; e++)
      for (int a = 0; a < n; a++)
        for (int s = 0; s < 2; s++)
          if (tb_ops[e][s] != 0) begin
            op_exp_t o;
            o.we = (tb_ops[e][s] >= 3);
            o.re = (tb_ops[e][s] <= 2);
            o.d  = (tb_ops[e][s] == 2) || (tb_ops[e][s] == 4);
            o.up = tb_up[e];
            opq.push_back(o);
          end
  endtask

  task automatic push_exp(input int g, input int edges, input logic f, input logic [2:0] fe,
                          input int nwe, input int nre);
    exp_t e;
    e.edges = edges; e.fail = f; e.fe = fe; e.nwe = nwe; e.nre = nre;
    if (g == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("launch%0d_busy_ld_nbart_done_fail_elem", g),
          {26'd0, busy[g], ld[g], NbarT[g], done[g], fail[g], elem_idx[g] == 3'd0},
          {26'd0, 6'b111001});
    end
  endtask

  task automatic check_run(input int g, input int edges);
    exp_t e;
    n_assert++;
    assert ((g == 0) ? (sb0.size() > 0) : (sb1.size() > 0)) else begin
      n_fail++;
      $error("FAIL sb%0d_empty observed=0 expected=1 pending entries", g);
    end
    if ((g == 0) ? (sb0.size() > 0) : (sb1.size() > 0)) begin
      if (g == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk($sformatf("run%0d_edges", g), edges, e.edges);
      chk($sformatf("run%0d_done_fail", g), {30'd0, done[g], fail[g]}, {30'd0, 1'b1, e.fail});
      chk($sformatf("run%0d_fail_elem", g), fail_elem[g], e.fe);
      chk($sformatf("run%0d_n_we", g), n_we[g], e.nwe);
      chk($sformatf("run%0d_n_re", g), n_re[g], e.nre);
    end
  endtask

  task automatic run_both(input int bound);
    int e0 = -1;
    int e1 = -1;
    for (int k = 1; k <= bound && (e0 < 0 || e1 < 0); k++) begin
      tick();
      if (e0 < 0 && done[0]) e0 = k;
      if (e1 < 0 && done[1]) e1 = k;
    end
    check_run(0, e0);
    check_run(1, e1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; max_addr = 2'd0;
    for (int g = 0; g < 2; g++) begin
      fault_on[g] = 1'b0; fault_elem[g] = '0; fault_read[g] = 0;
    end

    // reset values
    tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d_ld_nbart_busy_done_fail", g),
          {27'd0, ld[g], NbarT[g], busy[g], done[g], fail[g]}, {27'd0, 5'b10000});
      chk($sformatf("rst%0d_strobes", g),
          {28'd0, mem_we[g], mem_re[g], cmp_en[g], cnt_en[g]}, 32'd0);
      chk($sformatf("rst%0d_pat_elem_fe", g), {18'd0, pat[g], elem_idx[g], fail_elem[g]}, 32'd0);
    end
    rst = 1'b0;

    // idle with a stray cout (single-address counter sits on its terminal address)
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ld_nbart_busy_done", {28'd0, ld[0], NbarT[0], busy[0], done[0]}, {28'd0, 4'b1000});
    end
    max_addr = 2'd3;

    // full clean pass
    push_exp(0, 47, 1'b0, 3'd0, 20, 20);
    push_exp(1, 49, 1'b0, 3'd0, 20, 20);
    push_ops(4);
    chk_ops = 1'b1;
    launch();
    run_both(200);
    chk_ops = 1'b0;
    chk("ops_left", opq.size(), 0);
    chk("down_ops", n_dn[0], 16);
    chk("down_outside_e3_e4", bad_dn[0], 0);

    // injected faults: 2nd read of element 2 (RD_LAT=1), last read of element 5 (RD_LAT=3)
    fault_on[0] = 1'b1; fault_elem[0] = 3'd2; fault_read[0] = 1;
    fault_on[1] = 1'b1; fault_elem[1] = 3'd5; fault_read[1] = 3;
`ifdef MBIST_FAIL_STOP_EN
    push_exp(0, 20, 1'b1, 3'd2, 10, 7);
`else
    push_exp(0, 47, 1'b1, 3'd2, 20, 20);
`endif
    push_exp(1, 49, 1'b1, 3'd5, 20, 20);
    launch();
    run_both(200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold", {30'd0, done[0], fail[0]}, {30'd0, 2'b11});
    end

    // restart from DONE after the failing run
    fault_on[0] = 1'b0; fault_on[1] = 1'b0;
    push_exp(0, 47, 1'b0, 3'd0, 20, 20);
    push_exp(1, 49, 1'b0, 3'd0, 20, 20);
    push_ops(4);
    chk_ops = 1'b1;
    launch();
    run_both(200);
    chk_ops = 1'b0;
    chk("ops_left_restart", opq.size(), 0);

    // reset in the middle of element 3
    launch();
    begin
      logic found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
        tick();
        if (elem_idx[0] == 3'd3 && !ld[0] && NbarT[0]) found = 1'b1;
      end
      chk("reach_elem3", found, 1'b1);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("midrst%0d_ld_nbart_busy_fail", g),
          {28'd0, ld[g], NbarT[g], busy[g], fail[g]}, {28'd0, 4'b1000});
      chk($sformatf("midrst%0d_elem", g), elem_idx[g], 3'd0);
    end
    tick();
    push_exp(0, 47, 1'b0, 3'd0, 20, 20);
    push_exp(1, 49, 1'b0, 3'd0, 20, 20);
    launch();
    run_both(200);

    // single-address memory: one pass per element
    max_addr = 2'd0;
    push_exp(0, 17, 1'b0, 3'd0, 5, 5);
    push_exp(1, 19, 1'b0, 3'd0, 5, 5);
    push_ops(1);
    chk_ops = 1'b1;
    launch();
    run_both(100);
    chk_ops = 1'b0;
    chk("ops_left_single", opq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
